ex_stage_pipe: RTL and testbench

- Parametrised, pipelined execute stage for the CPU datapath. Successor to the single-cycle execute block.
- Selects the ALU B operand, computes the ALU result and NZVC flags, and computes the PC-relative branch target.
- Registers all results in one output stage with a valid/ready handshake, plus flush support.
- Holds the architectural NZVC flag register, updated only by accepted, non-flushed flag-setting operations.

---
 rtl/ex_stage_pipe.sv | 100 ++++++++++
 tb/tb_ex_stage_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_pipe.sv
// Pipelined execute stage: B-operand select, ALU with NZVC flags, PC-relative branch
// target, one registered output stage with valid/ready handshake and flush.
module ex_stage_pipe #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic [WIDTH-1:0] br_offset,
    input  logic [2:0]       alu_op,
    input  logic             alu_src,
    input  logic             set_flags,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] store_data,
    output logic [WIDTH-1:0] branch_target,
    output logic [3:0]       flags
);

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110
    } alu_op_e;

    alu_op_e          op;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] b_add;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] target;
    logic             cin;
    logic             n_f, z_f, v_f, c_f;
    logic             accept;

    assign op       = alu_op_e'(alu_op);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign target   = pc + (br_offset << BR_SHIFT);

    // Subtract shares the adder as A + ~B + 1, so C is the no-borrow carry.
    always_comb begin
        b_op  = alu_src ? imm_ext : read_data2;
        cin   = (op == OP_SUB);
        b_add = cin ? ~b_op : b_op;
        sum   = {1'b0, read_data1} + {1'b0, b_add} + {{WIDTH{1'b0}}, cin};
        res   = '0;
        v_f   = 1'b0;
        c_f   = 1'b0;
        case (op)
            OP_PASS: res = b_op;
            OP_ADD, OP_SUB: begin
                res = sum[WIDTH-1:0];
                c_f = sum[WIDTH];
                v_f = (read_data1[WIDTH-1] == b_add[WIDTH-1]) &&
                      (res[WIDTH-1] != read_data1[WIDTH-1]);
            end
            OP_AND:  res = read_data1 & b_op;
            OP_OR:   res = read_data1 | b_op;
            OP_XOR:  res = read_data1 ^ b_op;
            default: res = '0;
        endcase
        n_f = res[WIDTH-1];
        z_f = (res == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            alu_result    <= '0;
            store_data    <= '0;
            branch_target <= '0;
            flags         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            alu_result    <= res;
            store_data    <= read_data2;
            branch_target <= target;
            if (set_flags) begin
                flags <= {n_f, z_f, v_f, c_f};
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe: directed vector table, random stream against
// a reference model via a scoreboard queue, plus stall/flush/reset sequences.
module tb_ex_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] read_data1, read_data2, pc, imm_ext, br_offset;
    logic [2:0]  alu_op;
    logic        alu_src, set_flags, flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] alu_result, store_data, branch_target;
    logic [3:0]  flags;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    ex_stage_pipe #(.WIDTH(64), .BR_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .read_data1(read_data1), .read_data2(read_data2), .pc(pc),
        .imm_ext(imm_ext), .br_offset(br_offset), .alu_op(alu_op),
        .alu_src(alu_src), .set_flags(set_flags), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .store_data(store_data), .branch_target(branch_target), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a, b, imm, pc, br;
        logic [2:0]  op;
        logic        src, sf;
        logic [63:0] res, bt;
        logic [3:0]  fl;
    } vec_t;

    typedef struct {
        logic [63:0] res, sd, bt;
        logic [3:0]  fl;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    logic [3:0] cur_flags;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                         input logic [63:0] p, input logic [63:0] br, input logic [2:0] op,
                         input logic src, input logic sf);
        read_data1 = a; read_data2 = b; imm_ext = imm; pc = p; br_offset = br;
        alu_op = op; alu_src = src; set_flags = sf; in_valid = 1'b1;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_res"}, alu_result, e.res);
            chk({tag, "_sd"}, store_data, e.sd);
            chk({tag, "_bt"}, branch_target, e.bt);
            chk({tag, "_flags"}, {60'd0, flags}, {60'd0, e.fl});
        end
    endtask

    // Independent reference: signed overflow via sign-extended arithmetic, C via compare.
    function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] op);
        logic [63:0] r;
        logic        v, c;
        logic signed [64:0] ss;
        logic [64:0] s;
        r = 64'd0; v = 1'b0; c = 1'b0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                s  = {1'b0, a} + {1'b0, b};
                ss = $signed({a[63], a}) + $signed({b[63], b});
                r  = s[63:0]; c = s[64]; v = ss[64] != ss[63];
            end
            3'b011: begin
                ss = $signed({a[63], a}) - $signed({b[63], b});
                r  = a - b; c = (a >= b); v = ss[64] != ss[63];
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = 64'd0;
        endcase
        return {r, r[63], (r == 64'd0), v, c};
    endfunction

    initial begin
        vecs[0]  = '{64'h2AA, 64'h155, 64'h0, 64'h0, 64'h0, 3'b010, 1'b0, 1'b0, 64'h3FF, 64'h0, 4'b0000};
        vecs[1]  = '{64'h2AA, 64'h155, 64'h1, 64'h100, 64'h20, 3'b011, 1'b1, 1'b1, 64'h2A9, 64'h180, 4'b0001};
        vecs[2]  = '{64'h8000_0000_0000_0000, 64'h1, 64'h0, 64'h0, 64'h0, 3'b011, 1'b0, 1'b1,
                     64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'b0011};
        vecs[3]  = '{64'hFFFF_FFFF_FFFF_FAAA, 64'h0, 64'h1, 64'h0, 64'h0, 3'b010, 1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FAAB, 64'h0, 4'b0011};
        vecs[4]  = '{64'hFFFF_FFFF_FFFF_FAAA, 64'h0, 64'h1, 64'h0, 64'h0, 3'b010, 1'b1, 1'b1,
                     64'hFFFF_FFFF_FFFF_FAAB, 64'h0, 4'b1000};
        vecs[5]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h0, 64'h0, 3'b010, 1'b0, 1'b1,
                     64'h8000_0000_0000_0000, 64'h0, 4'b1010};
        vecs[6]  = '{64'h5, 64'h5, 64'h0, 64'h0, 64'h0, 3'b011, 1'b0, 1'b1, 64'h0, 64'h0, 4'b0101};
        vecs[7]  = '{64'hF0F0, 64'hFF00, 64'h0, 64'h0, 64'h0, 3'b100, 1'b0, 1'b1, 64'hF000, 64'h0, 4'b0000};
        vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h0, 64'h0, 3'b110, 1'b0, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 4'b1000};
        vecs[9]  = '{64'h5, 64'h3, 64'h0, 64'h0, 64'h0, 3'b111, 1'b0, 1'b1, 64'h0, 64'h0, 4'b0100};
        vecs[10] = '{64'h1234, 64'h8000_0000_0000_0001, 64'h0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC,
                     3'b000, 1'b0, 1'b1, 64'h8000_0000_0000_0001, 64'hFF0, 4'b1000};
        vecs[11] = '{64'h0F, 64'h0, 64'hF0, 64'h2000, 64'h4000_0000_0000_0001, 3'b101, 1'b1, 1'b0,
                     64'hFF, 64'h2004, 4'b1000};
        vecs[12] = '{64'h7, 64'h9, 64'h0, 64'h0, 64'h0, 3'b001, 1'b0, 1'b1, 64'h0, 64'h0, 4'b0100};

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        read_data1 = '0; read_data2 = '0; pc = '0; imm_ext = '0; br_offset = '0;
        alu_op = '0; alu_src = 1'b0; set_flags = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_flags", {60'd0, flags}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_result", alu_result, 64'd0);
        cur_flags = 4'b0000;

        // Directed table, back-to-back at full throughput.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].pc, vecs[i].br,
                  vecs[i].op, vecs[i].src, vecs[i].sf);
            chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
            sb.push_back('{vecs[i].res, vecs[i].b, vecs[i].bt, vecs[i].fl});
            cur_flags = vecs[i].fl;
            step();
            chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
            pop_compare($sformatf("vec%0d", i));
        end
        in_valid = 1'b0;
        step();
        chk("drain_out_valid", {63'd0, out_valid}, 64'd0);

        // Random stream with bubbles, checked against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [63:0] a, b, imm, p, br, bsel;
            logic [67:0] m;
            logic [2:0]  op;
            logic        src, sf, v;
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            imm = {$urandom, $urandom};
            p   = {$urandom, $urandom};
            br  = {$urandom, $urandom};
            op  = 3'($urandom_range(0, 7));
            src = 1'($urandom_range(0, 1));
            sf  = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 3) != 0);
            if (i % 8 == 3) begin
                b = a;
                op = 3'b011;
            end
            bsel = src ? imm : b;
            m = model(a, bsel, op);
            drive(a, b, imm, p, br, op, src, sf);
            in_valid = v;
            if (v) begin
                if (sf) cur_flags = m[3:0];
                sb.push_back('{m[67:4], b, p + {br[61:0], 2'b00}, cur_flags});
            end
            step();
            chk($sformatf("rnd%0d_out_valid", i), {63'd0, out_valid}, {63'd0, v});
            if (out_valid) pop_compare($sformatf("rnd%0d", i));
        end
        in_valid = 1'b0;
        step();
        chk("rnd_drain", {63'd0, out_valid}, 64'd0);

        // Stall: held output must not change and a new op must not be accepted.
        out_ready = 1'b0;
        drive(64'h10, 64'h20, 64'h0, 64'h40, 64'h1, 3'b010, 1'b0, 1'b0);
        step();
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_res", alu_result, 64'h30);
        drive(64'h1, 64'h1, 64'h0, 64'h0, 64'h0, 3'b010, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
            step();
            chk($sformatf("stall%0d_valid", k), {63'd0, out_valid}, 64'd1);
            chk($sformatf("stall%0d_res", k), alu_result, 64'h30);
            chk($sformatf("stall%0d_sd", k), store_data, 64'h20);
            chk($sformatf("stall%0d_bt", k), branch_target, 64'h44);
            chk($sformatf("stall%0d_flags", k), {60'd0, flags}, {60'd0, cur_flags});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("stall_release_valid", {63'd0, out_valid}, 64'd0);
        chk("stall_release_res", alu_result, 64'h30);

        // Flush on the accept cycle discards the op and its flag update.
        drive(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h0, 64'h0, 3'b010, 1'b0, 1'b1);
        flush = 1'b1;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_flags", {60'd0, flags}, {60'd0, cur_flags});

        // Reset while an op is held under stall.
        out_ready = 1'b0;
        drive(64'h8000_0000_0000_0000, 64'h1, 64'h0, 64'h8, 64'h1, 3'b011, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        chk("prerst_valid", {63'd0, out_valid}, 64'd1);
        chk("prerst_flags", {60'd0, flags}, 64'h3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_flags", {60'd0, flags}, 64'd0);
        chk("midrst_res", alu_result, 64'd0);
        chk("midrst_sd", store_data, 64'd0);
        chk("midrst_bt", branch_target, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
